// File: rtl/period_sequencer.sv
// Purpose : run controller for a terminal-count counter; latches the compare value,
//           issues clear and prescaled enable strobes, and counts tc rising edges to done.
// Latency : start accepted on the clock it is sampled in IDLE; cnt_clr the next cycle;
//           done one clock after the tc edge that completes the run.
// Backpressure: none; start is ignored while busy or in DONE, and abort overrides everything but r.
//
// Ports:
//   clk, r             rising-edge clock, synchronous active-high reset
//   start, abort       run control (abort wins over start)
//   period, prescale,  run configuration, latched on an accepted start
//   repeats
//   tc_in              terminal-count level from the downstream counter
//   data_out           latched period, drives the counter's data input
//   e_out, cnt_clr     enable strobe and one-cycle clear pulse to the counter
//   busy, done         busy in LOAD/RUN; one-cycle done pulse
//   rep_cnt            tc edges seen in the current run (saturating)
//
// Build option: define AUTO_RELOAD_EN so DONE restarts the run (DONE -> LOAD) with the
// latched values instead of returning to IDLE.

module period_sequencer #(
    parameter int SIZE  = 4,
    parameter int PSC_W = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             abort,
    input  logic [SIZE-1:0]  period,
    input  logic [PSC_W-1:0] prescale,
    input  logic [REP_W-1:0] repeats,
    input  logic             tc_in,
    output logic [SIZE-1:0]  data_out,
    output logic             e_out,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] rep_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [PSC_W-1:0] psc_l;
    logic [PSC_W-1:0] pcnt;
    logic [REP_W-1:0] rep_l;
    logic             tc_prev;

    logic             tc_edge;
    logic             term_edge;
    logic [REP_W-1:0] rep_inc;

    // Rising edge of tc_in, only meaningful while running.
    assign tc_edge   = (state == S_RUN) && tc_in && !tc_prev;
    // Saturating increment: rep_cnt sticks at all-ones rather than wrapping.
    assign rep_inc   = (rep_cnt == {REP_W{1'b1}}) ? rep_cnt : rep_cnt + REP_W'(1);
    // The edge that reaches the latched repeat count ends the run.
    assign term_edge = tc_edge && (rep_inc == rep_l);

    // Strobes are decoded from registered state; abort masks them in the abort cycle
    // itself, and the completing edge masks the enable in its own cycle.
    assign e_out   = (state == S_RUN) && (pcnt == '0) && !term_edge && !abort;
    assign cnt_clr = (state == S_LOAD) && !abort;
    assign done    = (state == S_DONE) && !abort;
    assign busy    = (state == S_LOAD) || (state == S_RUN);

    always_ff @(posedge clk) begin
        if (r) begin
            state    <= S_IDLE;
            data_out <= '0;
            psc_l    <= '0;
            rep_l    <= '0;
            pcnt     <= '0;
            tc_prev  <= 1'b0;
            rep_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tc_prev <= 1'b0;
                    if (start && !abort) begin
                        data_out <= period;
                        psc_l    <= prescale;
                        rep_l    <= repeats;
                        rep_cnt  <= '0;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    pcnt    <= psc_l;
                    // History restarts from the level seen here, so a tc_in that is
                    // already high when RUN begins is not mistaken for an edge.
                    tc_prev <= tc_in;
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (rep_l == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        tc_prev <= tc_in;
                        if (pcnt == '0) begin
                            pcnt <= psc_l;
                        end else begin
                            pcnt <= pcnt - PSC_W'(1);
                        end
                        if (tc_edge) begin
                            rep_cnt <= rep_inc;
                        end
                        if (term_edge) begin
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    tc_prev <= 1'b0;
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
`ifdef AUTO_RELOAD_EN
                        // Restart with the latched configuration; progress starts over.
                        rep_cnt <= '0;
                        state   <= S_LOAD;
`else
                        state   <= S_IDLE;
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
